// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: scan request/result bundle plus detector hookup.
// The slave side is the scan controller; the master side is the producer.
interface pattern_scan_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] word;
  logic             busy;
  logic             done;
  logic             found;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] first_pos;
  logic             det_in;
  logic             det_reset;
  logic             det_out;

  modport slave (
    input  start, word, det_out,
    output busy, done, found,
    output match_count, first_pos,
    output det_in, det_reset
  );

  modport master (
    output start, word, det_out,
    input  busy, done, found,
    input  match_count, first_pos,
    input  det_in, det_reset
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: shifts a word MSB-first into a Moore detector and
// tallies how many bit positions fired and where the first one was.
module pattern_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              reset,
  pattern_scan_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] KLAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pos;
  logic             fnd;
  logic             busy_q;
  logic             done_q;
  logic             din_q;
  logic             hit;
  logic [CNT_W-1:0] hit_pos;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.found       = fnd;
  assign bus.match_count = cnt;
  assign bus.first_pos   = pos;
  assign bus.det_in      = din_q;
  assign bus.det_reset   = reset | (state == CLEAR);

  // Detector output lags by one clock, so it belongs to the previous bit.
  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    if (state == SHIFT && k != '0) begin
      hit     = bus.det_out;
      hit_pos = k - CNT_W'(1);
    end else if (state == DRAIN) begin
      hit     = bus.det_out;
      hit_pos = KLAST;
    end
  end

  // Scan sequencer with registered outputs and result accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      k      <= '0;
      cnt    <= '0;
      pos    <= '0;
      fnd    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      din_q  <= 1'b0;
    end else begin
      if (hit) begin
        cnt <= cnt + CNT_W'(1);
        if (!fnd) begin
          pos <= hit_pos;
          fnd <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sreg   <= bus.word;
            busy_q <= 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          fnd   <= 1'b0;
          pos   <= '0;
          k     <= '0;
          din_q <= sreg[WIDTH-1];
          sreg  <= sreg << 1;
          state <= SHIFT;
        end
        SHIFT: begin
          k <= k + CNT_W'(1);
          if (k == KLAST) begin
            din_q <= 1'b0;
            state <= DRAIN;
          end else begin
            din_q <= sreg[WIDTH-1];
            sreg  <= sreg << 1;
          end
        end
        DRAIN: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
